// File: rtl/ad7606_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ad7606_pkg
//  Description : Shared constants and state encoding for the AD7606
//                acquisition scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package ad7606_pkg;

    localparam int NCH        = 8;     // ADC channel count
    localparam int DW         = 16;    // sample width
    localparam int CH_W       = 3;     // channel index width
    localparam int MIN_PERIOD = 64;    // smallest honoured sample period
    localparam int DONE_TMO   = 1024;  // cycles allowed from adc_start to adc_done
    localparam int TMO_W      = $clog2(DONE_TMO);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_CONV      = 2'd2,
        ST_EMIT      = 2'd3
    } acq_state_t;

endpackage : ad7606_pkg
`default_nettype wire

// File: rtl/ad7606_period_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ad7606_period_timer
//  Description : Sample-period down-counter. Loads max(period,MIN_PERIOD)-1,
//                counts down while enabled and ticks for one cycle at zero,
//                reloading on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad7606_period_timer #(
    parameter int PERIOD_W   = 24,
    parameter int MIN_PERIOD = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] c_min_period = PERIOD_W'(MIN_PERIOD);

    logic [PERIOD_W-1:0] r_reload;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_load_val;

    // Clamp short periods, then convert to a terminal count
    always_comb begin
        w_load_val = ((period < c_min_period) ? c_min_period : period) - PERIOD_W'(1);
    end

    // A load cycle never ticks; the first tick lands P cycles after it
    assign tick = enable & ~load & (r_cnt == '0);

    // Reload value capture and down-count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reload <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_reload <= w_load_val;
            r_cnt    <= w_load_val;
        end else if (enable) begin
            r_cnt <= (r_cnt == '0) ? r_reload : (r_cnt - PERIOD_W'(1));
        end
    end

endmodule : ad7606_period_timer
`default_nettype wire

// File: rtl/ad7606_acq_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ad7606_acq_scheduler
//  Description : Issues timed conversion requests to the AD7606 driver,
//                captures each 8-channel result and serialises the enabled
//                channels onto a valid/ready stream. Flags skipped period
//                ticks (overrun) and missing adc_done (timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module ad7606_acq_scheduler
    import ad7606_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [CNT_W-1:0]    cfg_count,
    input  logic [NCH-1:0]      cfg_ch_mask,
    input  logic                cmd_start,
    input  logic                cmd_stop,
    output logic                adc_start,
    input  logic                adc_done,
    input  logic [NCH*DW-1:0]   adc_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DW-1:0]       m_data,
    output logic [CH_W-1:0]     m_chan,
    output logic                m_last,
    output logic                busy,
    output logic                overrun,
    output logic [15:0]         overrun_cnt,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    samples_done
);

    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(DONE_TMO - 1);

    // Lowest enabled channel with index >= from (0 when none)
    function automatic logic [CH_W-1:0] f_lowest_from(input logic [NCH-1:0] mask,
                                                      input int             from);
        logic [CH_W-1:0] res;
        res = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k] && (k >= from)) res = CH_W'(k);
        end
        return res;
    endfunction

    // True when some enabled channel lies strictly above cur
    function automatic logic f_any_above(input logic [NCH-1:0] mask, input int cur);
        logic res;
        res = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (mask[k] && (k > cur)) res = 1'b1;
        end
        return res;
    endfunction

    acq_state_t             r_state;
    acq_state_t             w_state_nxt;

    logic [CNT_W-1:0]       r_count;
    logic [NCH-1:0]         r_mask;
    logic [NCH-1:0][DW-1:0] r_snap;
    logic [CH_W-1:0]        r_ch;
    logic                   r_stop_pend;
    logic [TMO_W-1:0]       r_tmo;
    logic                   r_adc_start;
    logic                   r_overrun;
    logic [15:0]            r_ovr_cnt;
    logic                   r_tmo_err;
    logic [CNT_W-1:0]       r_samples;

    logic                   w_tick;
    logic                   w_busy;
    logic                   w_start;
    logic                   w_fire;
    logic                   w_capture;
    logic                   w_timeout;
    logic                   w_advance;
    logic                   w_frame_done;
    logic                   w_skip;
    logic                   w_last;
    logic [CH_W-1:0]        w_first_ch;
    logic [CH_W-1:0]        w_next_ch;
    logic [CNT_W-1:0]       w_samples_inc;

    assign w_busy        = (r_state != ST_IDLE);
    assign w_first_ch    = f_lowest_from(r_mask, 0);
    assign w_next_ch     = f_lowest_from(r_mask, int'(r_ch) + 1);
    assign w_last        = ~f_any_above(r_mask, int'(r_ch));
    assign w_samples_inc = r_samples + CNT_W'(1);

    ad7606_period_timer #(
        .PERIOD_W   (PERIOD_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_start),
        .enable (w_busy),
        .period (cfg_period),
        .tick   (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_fire       = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_advance    = 1'b0;
        w_frame_done = 1'b0;
        w_skip       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_start && (cfg_ch_mask != '0) && !cmd_stop) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CONV;
                end
            end
            ST_WAIT_TICK: begin
                // A stop wins over a coincident tick: no further conversion
                if (cmd_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    w_fire      = 1'b1;
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                w_skip = w_tick;
                if (adc_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_EMIT;
                end else if (r_tmo == c_tmo_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = (r_stop_pend || cmd_stop) ? ST_IDLE : ST_WAIT_TICK;
                end
            end
            ST_EMIT: begin
                w_skip = w_tick;
                if (m_ready) begin
                    if (w_last) begin
                        w_frame_done = 1'b1;
                        if (((r_count != '0) && (w_samples_inc == r_count)) ||
                            r_stop_pend || cmd_stop)
                            w_state_nxt = ST_IDLE;
                        else
                            w_state_nxt = ST_WAIT_TICK;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Run configuration, snapshot, channel walk and status bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_mask      <= '0;
            r_snap      <= '0;
            r_ch        <= '0;
            r_stop_pend <= 1'b0;
            r_tmo       <= '0;
            r_adc_start <= 1'b0;
            r_overrun   <= 1'b0;
            r_ovr_cnt   <= '0;
            r_tmo_err   <= 1'b0;
            r_samples   <= '0;
        end else begin
            r_adc_start <= w_start | w_fire;
            r_tmo       <= (r_state == ST_CONV) ? (r_tmo + TMO_W'(1)) : '0;
            if (w_start) begin
                r_count     <= cfg_count;
                r_mask      <= cfg_ch_mask;
                r_stop_pend <= 1'b0;
                r_overrun   <= 1'b0;
                r_ovr_cnt   <= '0;
                r_tmo_err   <= 1'b0;
                r_samples   <= '0;
            end
            if (((r_state == ST_CONV) || (r_state == ST_EMIT)) && cmd_stop)
                r_stop_pend <= 1'b1;
            if (w_capture) begin
                r_snap <= adc_data;
                r_ch   <= w_first_ch;
            end
            if (w_advance)
                r_ch <= w_next_ch;
            if (w_skip) begin
                r_overrun <= 1'b1;
                if (r_ovr_cnt != 16'hFFFF) r_ovr_cnt <= r_ovr_cnt + 16'd1;
            end
            if (w_timeout)
                r_tmo_err <= 1'b1;
            if (w_frame_done)
                r_samples <= w_samples_inc;
        end
    end

    // Stream fields are zeroed whenever no word is offered
    assign m_valid      = (r_state == ST_EMIT);
    assign m_data       = m_valid ? r_snap[r_ch] : '0;
    assign m_chan       = m_valid ? r_ch : '0;
    assign m_last       = m_valid & w_last;
    assign busy         = w_busy;
    assign adc_start    = r_adc_start;
    assign overrun      = r_overrun;
    assign overrun_cnt  = r_ovr_cnt;
    assign timeout_err  = r_tmo_err;
    assign samples_done = r_samples;

endmodule : ad7606_acq_scheduler
`default_nettype wire
